// File: rtl/mem_indirect_seq_if.sv
// Memory-side bus of the indirect-access sequencer: request, address and response.
interface mem_indirect_seq_if #(
  parameter int DATA_W   = 16,
  parameter int OFFSET_W = 4
);
  localparam int AW = DATA_W - OFFSET_W;

  logic                mem_read;
  logic                mem_write;
  logic [AW-1:0]       mem_address;
  logic [OFFSET_W-1:0] line_offset_out;
  logic                mem_resp;
  logic [DATA_W-1:0]   mem_rdata;

  // The sequencer drives requests and consumes responses.
  modport master (
    output mem_read, mem_write, mem_address, line_offset_out,
    input  mem_resp, mem_rdata
  );

  // The memory consumes requests and drives responses.
  modport slave (
    input  mem_read, mem_write, mem_address, line_offset_out,
    output mem_resp, mem_rdata
  );
endinterface

// File: rtl/mem_indirect_seq.sv
// Memory-stage indirect-access sequencer. A direct access passes straight
// through; an indirect instruction chains up to MAX_IND pointer loads, with
// the final access being a read (LDI) or a write (STI), while the pipeline
// is held frozen.
module mem_indirect_seq #(
  parameter int DATA_W   = 16,
  parameter int OFFSET_W = 4,
  parameter int MAX_IND  = 2,
  localparam int AW      = DATA_W - OFFSET_W,
  localparam int CW      = $clog2(MAX_IND + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read_in,
  input  logic                mem_write_in,
  input  logic [AW-1:0]       mem_address_in,
  input  logic [OFFSET_W-1:0] line_offset_in,
  input  logic [CW-1:0]       ind_level,
  input  logic                ind_store,
  input  logic                flushed,
  input  logic                ifetch_resp,
  mem_indirect_seq_if.master  mem,
  output logic                stall_pipeline,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, IND, WAIT_IF} state_t;

  localparam logic [CW-1:0] MAX_L = CW'(MAX_IND);
  localparam logic [CW-1:0] ONE   = CW'(1);

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] ptr_reg;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              ptr_load;
  logic [CW-1:0]     level;

  // Clamp the requested indirection depth so the level can never exceed MAX_IND.
  always_comb begin
    level = (ind_level > MAX_L) ? MAX_L : ind_level;
  end

  // State, pointer and remaining-level registers; reset abandons any sequence at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (ptr_load) begin
        ptr_reg <= mem.mem_rdata;
      end
    end
  end

  // Next-state and memory/stall outputs, combinational from state and inputs.
  always_comb begin
    state_next          = state_reg;
    cnt_next            = cnt_reg;
    ptr_load            = 1'b0;
    mem.mem_read        = mem_read_in;
    mem.mem_write       = mem_write_in;
    mem.mem_address     = mem_address_in;
    mem.line_offset_out = line_offset_in;
    stall_pipeline      = ((mem_read_in | mem_write_in) & ~mem.mem_resp) | ~ifetch_resp;

    unique case (state_reg)
      IDLE: begin
        // The first access of an indirect instruction is the pipeline's own
        // request; its data becomes the first pointer.
        if (level != '0 && !flushed) begin
          stall_pipeline = 1'b1;
          if (mem.mem_resp) begin
            ptr_load   = 1'b1;
            cnt_next   = level;
            state_next = IND;
          end
        end
      end

      IND: begin
        mem.mem_address     = ptr_reg[DATA_W-1:OFFSET_W];
        mem.line_offset_out = ptr_reg[OFFSET_W-1:0];
        mem.mem_write       = (cnt_reg == ONE) & ind_store;
        mem.mem_read        = ~((cnt_reg == ONE) & ind_store);
        stall_pipeline      = 1'b1;
        if (mem.mem_resp) begin
          if (cnt_reg > ONE) begin
            ptr_load = 1'b1;
            cnt_next = cnt_reg - ONE;
          end else if (ifetch_resp) begin
            stall_pipeline = 1'b0;
            state_next     = IDLE;
          end else begin
            state_next = WAIT_IF;
          end
        end
      end

      WAIT_IF: begin
        // Final access already completed; only the fetch side is outstanding.
        mem.mem_address     = ptr_reg[DATA_W-1:OFFSET_W];
        mem.line_offset_out = ptr_reg[OFFSET_W-1:0];
        mem.mem_read        = 1'b0;
        mem.mem_write       = 1'b0;
        stall_pipeline      = ~ifetch_resp;
        if (ifetch_resp) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A sequence is in progress whenever the sequencer has left IDLE.
  always_comb begin
    busy = (state_reg != IDLE);
  end

endmodule

// File: doc/mem_indirect_seq.md
MEM_INDIRECT_SEQ -- requirements
Module: mem_indirect_seq

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_W, 16, data and pointer width.
REQ-002 OFFSET_W, 4, line-offset width; address width AW = DATA_W-OFFSET_W.
REQ-003 MAX_IND, 2, maximum indirection levels (>=1); counter width CW = $clog2(MAX_IND+1).
REQ-004 Ports SHALL be (name direction width meaning):
- clk  in  1  clock; one clock domain only.
- rst  in  1  asynchronous, active-high reset.
- mem_read_in  in  1  pipeline memory read request.
- mem_write_in  in  1  pipeline memory write request.
- mem_address_in  in  AW  pipeline line address.
- line_offset_in  in  OFFSET_W  pipeline line offset.
- ind_level  in  CW  indirection levels of the current instruction (0 = direct).
- ind_store  in  1  final indirect access is a write (STI-class); 0 = read (LDI-class).
- flushed  in  1  current memory-stage instruction is squashed.
- mem_resp  in  1  data-memory response.
- ifetch_resp  in  1  instruction-fetch response.
- mem_rdata  in  DATA_W  data-memory read data.
- mem_read  out  1  read request to memory.
- mem_write  out  1  write request to memory.
- mem_address  out  AW  line address to memory.
- line_offset_out  out  OFFSET_W  offset to memory.
- stall_pipeline  out  1  freeze all pipeline registers.
- busy  out  1  indirect sequence in progress (state != IDLE).

Function
REQ-005 States SHALL be IDLE, IND and WAIT_IF; outputs are combinational from state and inputs.
REQ-006 Effective level L = min(ind_level, MAX_IND); the level is never allowed to exceed MAX_IND.
REQ-007 IDLE, L==0 or flushed==1: memory outputs pass inputs through; stall_pipeline = ((mem_read_in|mem_write_in) & !mem_resp) | !ifetch_resp.
REQ-008 IDLE, L>0 and flushed==0: pass-through request; stall_pipeline = 1 unconditionally.
REQ-009 IDLE, L>0, flushed==0, mem_resp==1: ptr <= mem_rdata; cnt <= L; next state IND.
REQ-010 ptr SHALL load only on a qualifying mem_resp, never on other cycles.
REQ-011 IND: mem_address = ptr[DATA_W-1:OFFSET_W]; line_offset_out = ptr[OFFSET_W-1:0].
REQ-012 IND: mem_write = (cnt==1 & ind_store); mem_read = !mem_write.
REQ-013 IND, mem_resp==1, cnt>1: ptr <= mem_rdata; cnt <= cnt-1; stay in IND; the next access is issued the following cycle.
REQ-014 IND, mem_resp==1, cnt==1, ifetch_resp==1: stall_pipeline = 0 this cycle; next state IDLE.
REQ-015 IND, mem_resp==1, cnt==1, ifetch_resp==0: stall held; next state WAIT_IF.
REQ-016 Otherwise in IND, stall_pipeline = 1.
REQ-017 WAIT_IF: mem_read = mem_write = 0; stall_pipeline = !ifetch_resp; on ifetch_resp==1 next state IDLE. The final access SHALL NOT be reissued.
REQ-018 flushed SHALL be ignored outside IDLE; an in-flight sequence always completes.
REQ-019 ind_level and ind_store SHALL be sampled as held stable by the stalled pipeline; no internal copy of ind_store is kept.
REQ-020 Latency for level L with single-cycle memory: L+1 memory accesses and L+1 cycles when ifetch_resp==1.

Reset
REQ-021 rst==1 SHALL force state=IDLE, ptr=0 and cnt=0 immediately, independent of clk.
REQ-022 During reset: busy = 0; all other outputs follow the IDLE pass-through rule.
REQ-023 Reset asserted mid-sequence SHALL abandon the sequence with no further indirect request issued.

Verification (DATA_W=16, OFFSET_W=4, MAX_IND=2)
REQ-024 Direct read: mem_read_in=1, addr 0x123, mem_resp after 3 cycles -> stall high for 3 cycles then low; busy stays 0.
REQ-025 LDI: L=1, first mem_rdata=0xABCD -> second access is a read of addr 0xABC, offset 0xD; stall drops on its mem_resp.
REQ-026 Double-indirect STI: L=2, ind_store=1, rdata 0x1000 then 0x2004 -> accesses are read 0x100/0, then write 0x200/4; exactly 3 accesses.
REQ-027 Clamp and flush: ind_level=3 -> exactly 3 accesses (L=2). flushed=1 in IDLE with L=1 -> direct behaviour, busy stays 0.
REQ-028 ifetch_resp low at final mem_resp -> WAIT_IF with mem_read=mem_write=0 and stall high until ifetch_resp; no reissue.
REQ-029 rst pulsed asynchronously in IND -> busy drops without a clock edge; the next cycle shows pass-through outputs.
